seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the two-digit multiplexed 7-segment display driver.

---
 rtl/seg_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the two-digit value shown on a multiplexed 7-segment bus.
// Latency: a digit stable before edge N is captured at edge N+STABLE_CYCLES-1.
//          The frame-completing capture is published one edge later.
// Backpressure: none; this is a passive monitor of the scanned bus.
// Ports: clk, rstn (sync, active low); seg[6:0] (active low, seg[0]=a), an[1:0] (active low,
//        an[0]=units); units/tens/value decoded outputs; valid/stale levels; update pulse;
//        err sticky.
// Optional build macro SEG_SCAN_DECODER_HEX_EN: glyphs A..F decode to 10..15 in either slot.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] seg,
   input  logic [1:0] an,
   output logic [3:0] units,
   output logic [3:0] tens,
   output logic [7:0] value,
   output logic       valid,
   output logic       update,
   output logic       stale,
   output logic       err
);

   localparam int CW = $clog2(STABLE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {COLLECT, COMMIT} state_t;

   state_t        state_q, state_d;
   logic [6:0]    s_seg_q;
   logic [1:0]    s_an_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          seen_u_q, seen_u_d, seen_t_q, seen_t_d;
   logic [3:0]    pend_u_q, pend_u_d, pend_t_q, pend_t_d;
   logic [3:0]    units_q, tens_q;
   logic [7:0]    value_q;
   logic          valid_q, stale_q, err_q;

   logic          armed_pre, fire, dec_ok, cap_u, cap_t, cap, bad, timeout, commit_go;
   logic [3:0]    dec_dig;

   // Returns {legal, digit}. Blank is only legal in the tens slot (leading-zero suppression).
   function automatic logic [4:0] decode(input logic [6:0] pat, input logic tens_slot);
      logic [4:0] r;
      case (pat)
         7'h40:   r = {1'b1, 4'd0};
         7'h79:   r = {1'b1, 4'd1};
         7'h24:   r = {1'b1, 4'd2};
         7'h30:   r = {1'b1, 4'd3};
         7'h19:   r = {1'b1, 4'd4};
         7'h12:   r = {1'b1, 4'd5};
         7'h02:   r = {1'b1, 4'd6};
         7'h78:   r = {1'b1, 4'd7};
         7'h00:   r = {1'b1, 4'd8};
         7'h10:   r = {1'b1, 4'd9};
         7'h7F:   r = {tens_slot, 4'd0};
`ifdef SEG_SCAN_DECODER_HEX_EN
         7'h08:   r = {1'b1, 4'd10};
         7'h03:   r = {1'b1, 4'd11};
         7'h46:   r = {1'b1, 4'd12};
         7'h21:   r = {1'b1, 4'd13};
         7'h06:   r = {1'b1, 4'd14};
         7'h0E:   r = {1'b1, 4'd15};
`endif
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   // Stability is judged on the value being registered this edge, so the capture lands on the
   // same edge that the counter reaches its terminal count.
   always_comb begin
      armed_pre = 1'b0;
      cnt_d     = cnt_q;
      if ({an, seg} != {s_an_q, s_seg_q}) begin
         cnt_d     = '0;
         armed_pre = 1'b1;
      end else begin
         armed_pre = armed_q;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      fire    = armed_pre && (cnt_d == CNT_MAX);
      armed_d = armed_pre && !fire;

      {dec_ok, dec_dig} = decode(seg, an == 2'b01);
      cap_u = fire && (an == 2'b10) && dec_ok;
      cap_t = fire && (an == 2'b01) && dec_ok;
      cap   = cap_u || cap_t;
      bad   = fire && ((an == 2'b00) || ((an != 2'b11) && !dec_ok));

      tmo_d = cap ? '0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1);
      timeout = !cap && (tmo_d == TMO_MAX);
   end

   // Next-state logic
   always_comb begin
      state_d = COLLECT;
      if (state_q == COLLECT && seen_u_q && seen_t_q) state_d = COMMIT;
   end

   // Pending digit bookkeeping; a capture on the commit edge belongs to the next frame.
   always_comb begin
      commit_go = (state_d == COMMIT);
      seen_u_d  = seen_u_q;
      seen_t_d  = seen_t_q;
      if (commit_go || timeout) begin
         seen_u_d = 1'b0;
         seen_t_d = 1'b0;
      end
      if (cap_u) seen_u_d = 1'b1;
      if (cap_t) seen_t_d = 1'b1;
      pend_u_d = cap_u ? dec_dig : pend_u_q;
      pend_t_d = cap_t ? dec_dig : pend_t_q;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= COLLECT;
         s_seg_q  <= 7'h7F;
         s_an_q   <= 2'b11;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         tmo_q    <= '0;
         seen_u_q <= 1'b0;
         seen_t_q <= 1'b0;
         pend_u_q <= '0;
         pend_t_q <= '0;
         units_q  <= '0;
         tens_q   <= '0;
         value_q  <= '0;
         valid_q  <= 1'b0;
         stale_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_seg_q  <= seg;
         s_an_q   <= an;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         tmo_q    <= tmo_d;
         seen_u_q <= seen_u_d;
         seen_t_q <= seen_t_d;
         pend_u_q <= pend_u_d;
         pend_t_q <= pend_t_d;
         if (bad) err_q <= 1'b1;
         if (commit_go) begin
            units_q <= pend_u_q;
            tens_q  <= pend_t_q;
            value_q <= {1'b0, pend_t_q, 3'b000} + {3'b000, pend_t_q, 1'b0} + {4'h0, pend_u_q};
            valid_q <= 1'b1;
            stale_q <= 1'b0;
         end else if (timeout) begin
            valid_q <= 1'b0;
            stale_q <= 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      update = (state_q == COMMIT);
      units  = units_q;
      tens   = tens_q;
      value  = value_q;
      valid  = valid_q;
      stale  = stale_q;
      err    = err_q;
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed bench for seg_scan_decoder with default parameters.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Update pulses are counted 1 time unit after each rising edge.
module tb_seg_scan_decoder;

   logic       clk = 1'b0;
   logic       rstn;
   logic [6:0] seg;
   logic [1:0] an;
   logic [3:0] units, tens;
   logic [7:0] value;
   logic       valid, update, stale, err;

   int n_cmp = 0;
   int n_bad = 0;
   int upd_cnt = 0;

   seg_scan_decoder dut (
      .clk    (clk),
      .rstn   (rstn),
      .seg    (seg),
      .an     (an),
      .units  (units),
      .tens   (tens),
      .value  (value),
      .valid  (valid),
      .update (update),
      .stale  (stale),
      .err    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (update === 1'b1) upd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      an   = 2'b11;
      seg  = 7'h7F;
      repeat (3) @(negedge clk);
      check("rst_units",  32'(units),  0);
      check("rst_tens",   32'(tens),   0);
      check("rst_value",  32'(value),  0);
      check("rst_valid",  32'(valid),  0);
      check("rst_update", 32'(update), 0);
      check("rst_stale",  32'(stale),  0);
      check("rst_err",    32'(err),    0);
      rstn = 1'b1;
      @(negedge clk);

      // Units 3 then tens 1; exact publish latency on the completing digit.
      upd_cnt = 0;
      drive(2'b10, 7'h30, 4);
      drive(2'b01, 7'h79, 2);
      check("t1_update_early", 32'(update), 0);
      @(negedge clk);
      check("t1_update_pulse", 32'(update), 1);
      check("t1_units", 32'(units), 3);
      check("t1_tens",  32'(tens),  1);
      check("t1_value", 32'(value), 13);
      check("t1_valid", 32'(valid), 1);
      check("t1_err",   32'(err),   0);
      drive(2'b11, 7'h7F, 4);
      check("t1_upd_count", 32'(upd_cnt), 1);

      // Blank tens is a leading zero.
      upd_cnt = 0;
      drive(2'b01, 7'h7F, 4);
      drive(2'b10, 7'h10, 4);
      drive(2'b11, 7'h7F, 3);
      check("t2_value", 32'(value), 9);
      check("t2_tens",  32'(tens),  0);
      check("t2_err",   32'(err),   0);
      check("t2_upd_count", 32'(upd_cnt), 1);

      // One-cycle glitch on units must not be captured.
      upd_cnt = 0;
      drive(2'b01, 7'h40, 4);
      drive(2'b10, 7'h24, 1);
      drive(2'b10, 7'h12, 4);
      drive(2'b11, 7'h7F, 3);
      check("t3_upd_count", 32'(upd_cnt), 1);
      check("t3_value", 32'(value), 5);

      // Timeout with blanked digits.
      upd_cnt = 0;
      drive(2'b11, 7'h7F, 20);
      check("t4_stale_early", 32'(stale), 0);
      check("t4_valid_early", 32'(valid), 1);
      drive(2'b11, 7'h7F, 50);
      check("t4_stale", 32'(stale), 1);
      check("t4_valid", 32'(valid), 0);
      check("t4_value_held", 32'(value), 5);
      check("t4_upd_count", 32'(upd_cnt), 0);
      drive(2'b10, 7'h30, 4);
      drive(2'b01, 7'h79, 4);
      drive(2'b11, 7'h7F, 3);
      check("t4_stale_clear", 32'(stale), 0);
      check("t4_valid_again", 32'(valid), 1);
      check("t4_value_new", 32'(value), 13);

      // an=00 sets sticky err.
      drive(2'b00, 7'h7F, 3);
      drive(2'b11, 7'h7F, 3);
      check("t5_err_set", 32'(err), 1);
      upd_cnt = 0;
      drive(2'b10, 7'h19, 4);
      drive(2'b01, 7'h24, 4);
      drive(2'b11, 7'h7F, 3);
      check("t5_value", 32'(value), 24);
      check("t5_err_sticky", 32'(err), 1);
      check("t5_upd_count", 32'(upd_cnt), 1);
      rstn = 1'b0;
      drive(2'b11, 7'h7F, 2);
      rstn = 1'b1;
      check("t5_err_cleared", 32'(err), 0);

      // Blank units is illegal.
      upd_cnt = 0;
      drive(2'b01, 7'h40, 4);
      drive(2'b10, 7'h7F, 4);
      drive(2'b11, 7'h7F, 3);
      check("t2b_err", 32'(err), 1);
      check("t2b_upd_count", 32'(upd_cnt), 0);
      rstn = 1'b0;
      drive(2'b11, 7'h7F, 2);
      rstn = 1'b1;

      // Reset mid-frame discards the partial units digit.
      upd_cnt = 0;
      drive(2'b10, 7'h30, 4);
      rstn = 1'b0;
      drive(2'b11, 7'h7F, 2);
      rstn = 1'b1;
      drive(2'b01, 7'h79, 4);
      drive(2'b11, 7'h7F, 3);
      check("t6_upd_count", 32'(upd_cnt), 0);
      check("t6_valid", 32'(valid), 0);
      check("t6_value", 32'(value), 0);
      drive(2'b10, 7'h12, 4);
      drive(2'b11, 7'h7F, 3);
      check("t6_upd_after", 32'(upd_cnt), 1);
      check("t6_value_after", 32'(value), 15);
      check("t6_err", 32'(err), 0);

`ifdef SEG_SCAN_DECODER_HEX_EN
      drive(2'b01, 7'h0E, 4);
      drive(2'b10, 7'h06, 4);
      drive(2'b11, 7'h7F, 3);
      check("hex_value", 32'(value), 164);
      check("hex_err", 32'(err), 0);
`else
      drive(2'b10, 7'h08, 4);
      drive(2'b11, 7'h7F, 3);
      check("nohex_err", 32'(err), 1);
      check("nohex_value_held", 32'(value), 15);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
